// File: rtl/ttl_fifo_16x4.sv
// 16x4 first-word-fall-through FIFO with count-decoded flags, a sticky
// misuse flag and a tri-state copy of the head word for a shared nibble bus.
module ttl_fifo_16x4 #(
    parameter int DEPTH = 16
) (
    input  logic CK,
    input  logic CLR_n,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic WR_n,
    input  logic RD_n,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    inout  wire  Y0,
    inout  wire  Y1,
    inout  wire  Y2,
    inout  wire  Y3,
    input  logic OE_n,
    output logic IR,
    output logic OR,
    output logic HF,
    output logic ERR
);

    localparam int DATA_W = 4;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [AW:0]       count;
    logic              err_q;

    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] head;
    logic              wr_req;
    logic              rd_req;
    logic              wr_acc;
    logic              rd_acc;
    logic              in_rdy;
    logic              out_rdy;

    assign din    = {D3, D2, D1, D0};
    assign wr_req = ~WR_n;
    assign rd_req = ~RD_n;

    // Flags come from the registered count only, so requests never loop
    // combinationally back into IR/OR.
    assign in_rdy  = (count != FULL_CNT);
    assign out_rdy = (count != '0);
    assign wr_acc  = wr_req & in_rdy;
    assign rd_acc  = rd_req & out_rdy;

    always_ff @(posedge CK or negedge CLR_n) begin
        if (!CLR_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge CK or negedge CLR_n) begin
        if (!CLR_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wp <= wp + AW'(1);
            end
            if (rd_acc) begin
                rp <= rp + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // Sticky until reset: any request the FIFO had to refuse.
            if ((wr_req & ~in_rdy) | (rd_req & ~out_rdy)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign head = mem[rp];

    assign Q0  = head[0];
    assign Q1  = head[1];
    assign Q2  = head[2];
    assign Q3  = head[3];
    assign IR  = in_rdy;
    assign OR  = out_rdy;
    assign HF  = (count >= HALF_CNT);
    assign ERR = err_q;

    assign Y0 = OE_n ? 1'bz : head[0];
    assign Y1 = OE_n ? 1'bz : head[1];
    assign Y2 = OE_n ? 1'bz : head[2];
    assign Y3 = OE_n ? 1'bz : head[3];

endmodule
